// File: rtl/mos6510_io_port.sv
// 6510 on-chip I/O port: DDR/DR registers, read-back mux ahead of the system bus,
// pin resolution with pull-ups, and the capacitive fade of pin-less port bits.
module mos6510_io_port #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [15:0] DDR_ADDR    = 16'h0000,
  parameter logic [15:0] DR_ADDR     = 16'h0001,
  parameter logic [7:0]  PULLUP_MASK = 8'hFF,
  parameter logic [7:0]  FLOAT_MASK  = 8'hC0,
  parameter int unsigned FADE_CYCLES = 350000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_en,
  input  logic [15:0]      ab,
  input  logic             we,
  input  logic [7:0]       dout,
  input  logic [7:0]       bus_di,
  output logic [7:0]       cpu_di,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po,
  output logic [WIDTH-1:0] po_oe,
  output logic [WIDTH-1:0] port_val,
  output logic             port_hit
);

  localparam int unsigned      CNT_W    = $clog2(FADE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FADE_CYCLES);
  localparam logic [WIDTH-1:0] PULL_W   = PULLUP_MASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FLOAT_W  = FLOAT_MASK[WIDTH-1:0];

  logic [WIDTH-1:0] r_ddr;
  logic [WIDTH-1:0] r_dr;
  logic [WIDTH-1:0] w_fade;
  logic [WIDTH-1:0] w_dr_rd;
  logic             w_hit_ddr;
  logic             w_hit_dr;
  logic             w_wr_ddr;
  logic             w_wr_dr;

  assign w_hit_ddr = (ab == DDR_ADDR);
  assign w_hit_dr  = (ab == DR_ADDR);
  assign port_hit  = w_hit_ddr | w_hit_dr;
  assign w_wr_ddr  = cpu_en & we & w_hit_ddr;
  assign w_wr_dr   = cpu_en & we & w_hit_dr;

  // Direction and data registers; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ddr <= '0;
      r_dr  <= '0;
    end else begin
      if (w_wr_ddr) r_ddr <= dout[WIDTH-1:0];
      if (w_wr_dr)  r_dr  <= dout[WIDTH-1:0];
    end
  end

  // Fade latch per pin-less bit: tracks dr while driven, decays after release.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (FLOAT_MASK[i]) begin : g_float
      logic [CNT_W-1:0] r_cnt;
      logic             r_fade;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_cnt  <= '0;
          r_fade <= 1'b0;
        end else if (r_ddr[i]) begin
          r_cnt  <= CNT_LOAD;
          r_fade <= r_dr[i];
        end else if (cpu_en && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_fade <= 1'b0;
        end
      end

      assign w_fade[i] = r_fade;
    end else begin : g_pin
      assign w_fade[i] = 1'b0;
    end
  end

  assign po       = r_dr;
  assign po_oe    = r_ddr;
  assign port_val = (r_ddr & r_dr) | (~r_ddr & PULL_W);
  assign w_dr_rd  = (r_ddr & r_dr) | (~r_ddr & ((FLOAT_W & w_fade) | (~FLOAT_W & pi)));

  // Port registers take precedence over external bus data.
  always_comb begin
    cpu_di = bus_di;
    if (w_hit_ddr)     cpu_di = 8'(r_ddr);
    else if (w_hit_dr) cpu_di = 8'(w_dr_rd);
  end

endmodule

// File: tb/tb_mos6510_io_port.sv
// Bench for mos6510_io_port: two parameterisations driven together, checked
// against a per-bit behavioural model, directed steps followed by random traffic.
module tb_mos6510_io_port;

  logic        clk = 1'b0;
  logic        reset_n, cpu_en, we;
  logic [15:0] ab;
  logic [7:0]  dout, bus_di, pi;

  logic [7:0]  cpu_di0, po0, oe0, pv0;
  logic        hit0;
  logic [7:0]  cpu_di1;
  logic [5:0]  po1, oe1, pv1;
  logic        hit1;

  int errors = 0;
  int checks = 0;

  int m_ddr [2];
  int m_dr  [2];
  int m_rem [2][8];
  int m_fade[2][8];

  always #5 clk = ~clk;

  mos6510_io_port #(
    .WIDTH(8), .DDR_ADDR(16'h0000), .DR_ADDR(16'h0001),
    .PULLUP_MASK(8'h5A), .FLOAT_MASK(8'hC0), .FADE_CYCLES(10)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .ab(ab), .we(we),
    .dout(dout), .bus_di(bus_di), .cpu_di(cpu_di0), .pi(pi),
    .po(po0), .po_oe(oe0), .port_val(pv0), .port_hit(hit0)
  );

  mos6510_io_port #(
    .WIDTH(6), .DDR_ADDR(16'h0000), .DR_ADDR(16'h0001),
    .PULLUP_MASK(8'h3F), .FLOAT_MASK(8'h30), .FADE_CYCLES(3)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .ab(ab), .we(we),
    .dout(dout), .bus_di(bus_di), .cpu_di(cpu_di1), .pi(pi[5:0]),
    .po(po1), .po_oe(oe1), .port_val(pv1), .port_hit(hit1)
  );

  function automatic int wdt(int k);   return (k == 0) ? 8 : 6;            endfunction
  function automatic int pull(int k);  return (k == 0) ? 'h5A : 'h3F;      endfunction
  function automatic int flt(int k);   return (k == 0) ? 'hC0 : 'h30;      endfunction
  function automatic int fcyc(int k);  return (k == 0) ? 10 : 3;           endfunction
  function automatic int msk(int k);   return (1 << wdt(k)) - 1;           endfunction

  function automatic int exp_pv(int k);
    return ((m_ddr[k] & m_dr[k]) | (~m_ddr[k] & pull(k))) & msk(k);
  endfunction

  function automatic int exp_read(int k);
    int r;
    if (ab == 16'h0000) return m_ddr[k];
    if (ab != 16'h0001) return int'(bus_di);
    r = 0;
    for (int i = 0; i < wdt(k); i++) begin
      int v;
      if ((m_ddr[k] >> i) & 1)  v = (m_dr[k] >> i) & 1;
      else if ((flt(k) >> i) & 1) v = m_fade[k][i];
      else                      v = int'(pi[i]);
      r |= v << i;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic hit;
    hit = (ab == 16'h0000) || (ab == 16'h0001);
    chk("po0",     16'(po0),     16'(m_dr[0]));
    chk("po_oe0",  16'(oe0),     16'(m_ddr[0]));
    chk("pval0",   16'(pv0),     16'(exp_pv(0)));
    chk("cpu_di0", 16'(cpu_di0), 16'(exp_read(0)));
    chk("hit0",    16'(hit0),    16'(hit));
    chk("po1",     16'(po1),     16'(m_dr[1]));
    chk("po_oe1",  16'(oe1),     16'(m_ddr[1]));
    chk("pval1",   16'(pv1),     16'(exp_pv(1)));
    chk("cpu_di1", 16'(cpu_di1), 16'(exp_read(1)));
    chk("hit1",    16'(hit1),    16'(hit));
  endtask

  // Model update for one clock edge using the inputs held across that edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_ddr[k] = 0;
        m_dr[k]  = 0;
        for (int i = 0; i < 8; i++) begin
          m_rem[k][i]  = 0;
          m_fade[k][i] = 0;
        end
      end else begin
        for (int i = 0; i < wdt(k); i++) begin
          if (((flt(k) >> i) & 1) == 0) continue;
          if ((m_ddr[k] >> i) & 1) begin
            m_fade[k][i] = (m_dr[k] >> i) & 1;
            m_rem[k][i]  = fcyc(k);
          end else if (cpu_en && m_rem[k][i] > 0) begin
            m_rem[k][i]--;
            if (m_rem[k][i] == 0) m_fade[k][i] = 0;
          end
        end
        if (cpu_en && we && ab == 16'h0000) m_ddr[k] = int'(dout) & msk(k);
        if (cpu_en && we && ab == 16'h0001) m_dr[k]  = int'(dout) & msk(k);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic w, input logic [15:0] a,
                     input logic [7:0] d, input logic [7:0] b, input logic [7:0] p);
    @(negedge clk);
    reset_n = r; cpu_en = e; we = w; ab = a; dout = d; bus_di = b; pi = p;
    #1 check_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b1, 1'b1, a, d, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic e);
    cyc(1'b1, e, 1'b0, 16'h0001, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    reset_n = 1'b0; cpu_en = 1'b1; we = 1'b1; ab = 16'h0001;
    dout = 8'hFF; bus_di = 8'h00; pi = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_ddr[k] = 0; m_dr[k] = 0;
      for (int i = 0; i < 8; i++) begin m_rem[k][i] = 0; m_fade[k][i] = 0; end
    end
    repeat (2) @(posedge clk);

    // Reset state and read mux with no port write yet
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 8'h00);
    #1 chk("rst_pval1", 16'(pv1), 16'h003F);
    cyc(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 8'h00);
    #1 chk("bus_pass0", 16'(cpu_di0), 16'h00A5);

    // DDR/DR writes and mixed read-back
    wr(16'h0000, 8'h2F);
    wr(16'h0001, 8'h37);
    rd(1'b1);
    #1 chk("mix_rd0", 16'(cpu_di0), 16'h0027);
    chk("mix_rd1", 16'(cpu_di1), 16'h0027);
    chk("mix_pv1", 16'(pv1), 16'h0037);

    // Writes without cpu_en are dropped
    cyc(1'b1, 1'b0, 1'b1, 16'h0001, 8'hAA, 8'h00, 8'h00);
    #1 chk("en_low_dr", 16'(po0), 16'h0037);
    wr(16'h0001, 8'h55);
    #1 chk("en_high_dr", 16'(po0), 16'h0055);

    // Fade timing across 10 enabled cycles with an idle gap
    wr(16'h0000, 8'hC0);
    wr(16'h0001, 8'hC0);
    wr(16'h0000, 8'h00);
    repeat (5) rd(1'b1);
    repeat (8) rd(1'b0);
    repeat (4) rd(1'b1);
    #1 chk("fade_p9", 16'(cpu_di0[7:6]), 16'h0003);
    rd(1'b1);
    #1 chk("fade_p10", 16'(cpu_di0[7:6]), 16'h0000);
    repeat (3) rd(1'b1);

    // Re-driving a fading bit reloads it with the current dr value
    wr(16'h0000, 8'hC0);
    wr(16'h0001, 8'hC0);
    wr(16'h0000, 8'h00);
    repeat (6) rd(1'b1);
    wr(16'h0001, 8'h40);
    wr(16'h0000, 8'h80);
    rd(1'b1);
    wr(16'h0000, 8'h00);
    #1 chk("reload_b7", 16'(cpu_di0[7]), 16'h0000);
    repeat (12) rd(1'b1);

    // Reset in the middle of a fade, over a concurrent write
    wr(16'h0000, 8'hC0);
    wr(16'h0001, 8'hC0);
    wr(16'h0000, 8'h00);
    repeat (3) rd(1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0001, 8'hFF, 8'h00, 8'h00);
    #1 chk("rst_po0", 16'(po0), 16'h0000);
    chk("rst_fade0", 16'(cpu_di0[7:6]), 16'h0000);
    chk("rst_pval0", 16'(pv0), 16'h005A);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      int sel;
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h0001 : 16'($urandom);
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
          a, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
